// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access sizes, FSM states
// and the byte-enable helper used by the lane aligner.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Widest supported word is 64 bytes; callers truncate to their own lane count.
   localparam int MAX_BYTES = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic [MAX_BYTES-1:0] calcByteEn(input logic [1:0] size,
                                                       input logic [5:0] lane);
      logic [MAX_BYTES-1:0] base;
      case (size)
         SZ_B:    base = MAX_BYTES'(4'h1);
         SZ_H:    base = MAX_BYTES'(4'h3);
         SZ_W:    base = MAX_BYTES'(4'hF);
         default: base = '0;
      endcase
      return base << lane;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data across byte lanes with
// byte enables, and extracts/extends load data. Assumes DATA_W >= 32.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = 2
) (
   input  logic [1:0]          size,
   input  logic [LANE_W-1:0]   lane,
   input  logic                isUnsigned,
   input  logic [DATA_W-1:0]   storeData,
   input  logic [DATA_W-1:0]   memWord,
   output logic [DATA_W-1:0]   storeRep,
   output logic [DATA_W/8-1:0] byteEn,
   output logic [DATA_W-1:0]   loadData
);

   localparam int BYTES = DATA_W / 8;

   logic [DATA_W-1:0] shifted;

   assign byteEn = BYTES'(calcByteEn(size, 6'(lane)));

   // Every lane carries the right-aligned datum; byteEn picks the live ones.
   for (genvar gi = 0; gi < BYTES; gi++) begin : gRep
      assign storeRep[8*gi +: 8] = (size == SZ_B) ? storeData[7:0] :
                                   (size == SZ_H) ? storeData[8*(gi%2) +: 8] :
                                                    storeData[8*(gi%4) +: 8];
   end

   assign shifted = memWord >> {lane, 3'b000};

   always_comb begin
      loadData = '0;
      case (size)
         SZ_B:    loadData = {{(DATA_W-8){~isUnsigned & shifted[7]}}, shifted[7:0]};
         SZ_H:    loadData = {{(DATA_W-16){~isUnsigned & shifted[15]}}, shifted[15:0]};
         SZ_W:    loadData = DATA_W'(shifted[31:0]);
         default: loadData = '0;
      endcase
   end

endmodule

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request and response channels, fixed access
// latency, sub-word accesses and error reporting for bad size/alignment/range.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int          BYTES    = DATA_W / 8;
   localparam int          LANE_W   = $clog2(BYTES);
   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT    = 33'(DEPTH * BYTES);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_e            stateReg, stateNext;
   logic [3:0]        cntReg, cntNext;
   logic              accept, commit;

   logic              weReg;
   logic [31:0]       addrReg;
   logic [1:0]        sizeReg;
   logic              unsignedReg;
   logic [DATA_W-1:0] wdataReg;
   logic [DATA_W-1:0] rdataReg;
   logic              errReg;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  wordIdx;
   logic [DATA_W-1:0] memWord, storeRep, loadData;
   logic [BYTES-1:0]  byteEn;
   logic              misaligned, outOfRange, badSize, accessErr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg    <= IDLE;
         cntReg      <= '0;
         weReg       <= 1'b0;
         addrReg     <= '0;
         sizeReg     <= '0;
         unsignedReg <= 1'b0;
         wdataReg    <= '0;
         rdataReg    <= '0;
         errReg      <= 1'b0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
         if (accept) begin
            weReg       <= req_we;
            addrReg     <= req_addr;
            sizeReg     <= req_size;
            unsignedReg <= req_unsigned;
            wdataReg    <= req_wdata;
         end
         if (commit) begin
            rdataReg <= (accessErr || weReg) ? '0 : loadData;
            errReg   <= accessErr;
         end
      end
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      accept    = 1'b0;
      commit    = 1'b0;
      case (stateReg)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               cntNext   = CNT_INIT;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (cntReg == 4'd0) begin
               commit    = 1'b1;
               stateNext = RESP;
            end else begin
               cntNext = cntReg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign req_ready = (stateReg == IDLE);
   assign rsp_valid = (stateReg == RESP);
   assign rsp_rdata = rdataReg;
   assign rsp_err   = errReg;

   assign misaligned = ((sizeReg == SZ_H) && addrReg[0]) ||
                       ((sizeReg == SZ_W) && (addrReg[1:0] != 2'b00));
   assign outOfRange = ({1'b0, addrReg} >= LIMIT);
   assign badSize    = (sizeReg == 2'd3);
   assign accessErr  = misaligned || outOfRange || badSize;

   assign wordIdx = addrReg[LANE_W +: IDX_W];
   assign memWord = mem[wordIdx];

   // Stores land only on the WAIT->RESP edge; a reset in WAIT leaves memory untouched.
   always_ff @(posedge clk) begin
      if (commit && weReg && !accessErr) begin
         for (int b = 0; b < BYTES; b++) begin
            if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeRep[8*b +: 8];
         end
      end
   end

   dmem_lane_align #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) uAlign (
      .size       (sizeReg),
      .lane       (addrReg[LANE_W-1:0]),
      .isUnsigned (unsignedReg),
      .storeData  (wdataReg),
      .memWord    (memWord),
      .storeRep   (storeRep),
      .byteEn     (byteEn),
      .loadData   (loadData)
   );

endmodule

// File: tb/tb_dmem_hs.sv
// Drives three dmem_hs instances (LATENCY 1, 2, 4) with one shared request
// stream and checks every cycle against a byte-level behavioural model.
module tb_dmem_hs;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;

   logic [NI-1:0] reqReady;
   logic [NI-1:0] rspValid;
   logic [NI-1:0] rspErr;
   logic [31:0]   rspRdata [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int latOf(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : gDut
      dmem_hs #(
         .DATA_W  (32),
         .DEPTH   (64),
         .LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 2 : 4))
      ) uDut (
         .clk          (clk),
         .reset        (reset),
         .req_valid    (req_valid),
         .req_ready    (reqReady[gi]),
         .req_we       (req_we),
         .req_addr     (req_addr),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_wdata    (req_wdata),
         .rsp_valid    (rspValid[gi]),
         .rsp_ready    (rsp_ready),
         .rsp_rdata    (rspRdata[gi]),
         .rsp_err      (rspErr[gi])
      );
   end

   function automatic void chk(input string nm, input int k,
                               input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d(L=%0d) t=%0t: got %h, expected %h",
                  nm, k, latOf(k), $time, got, exp);
      end
   endfunction

   function automatic void failNow(input string nm);
      checks++;
      errors++;
      $display("FAIL %s t=%0t: bounded wait expired", nm, $time);
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0]  mm [NI][256];
   logic        mBusy [NI];
   logic        mDone [NI];
   logic        mZero [NI];
   int          mAcc [NI];
   logic        mWe [NI];
   logic [31:0] mAddr [NI];
   logic [1:0]  mSize [NI];
   logic        mUns [NI];
   logic [31:0] mWdata [NI];
   logic [31:0] mRdata [NI];
   logic        mErr [NI];
   int          cyc = 0;
   int          txn = 0;

   task automatic modelAccess(input int k);
      int n;
      int a;
      logic [31:0] v;
      logic e;
      n = (mSize[k] == 2'd0) ? 1 : ((mSize[k] == 2'd1) ? 2 : 4);
      a = int'(mAddr[k] % 32'd512);
      e = (mSize[k] == 2'd3) || ((mAddr[k] % 32'(n)) != 0) || (mAddr[k] >= 32'd256);
      v = '0;
      if (!e) begin
         if (mWe[k]) begin
            for (int i = 0; i < n; i++) mm[k][a+i] = mWdata[k][8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[k][a+i];
            if (n < 4 && !mUns[k] && v[8*n-1]) begin
               for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            end
         end
      end
      mRdata[k] = v;
      mErr[k]   = e;
      if (k == 1) begin
         txn++;
         $display("txn %0d %s addr=%h size=%0d uns=%0b wdata=%h -> rdata=%h err=%0b",
                  txn, mWe[k] ? "ST" : "LD", mAddr[k], mSize[k], mUns[k], mWdata[k], v, e);
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         mBusy[k] = 1'b0; mDone[k] = 1'b0; mZero[k] = 1'b1;
         mRdata[k] = '0; mErr[k] = 1'b0; mAcc[k] = 0;
      end
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            for (int k = 0; k < NI; k++) begin
               mBusy[k] = 1'b0; mDone[k] = 1'b0; mZero[k] = 1'b1;
               mRdata[k] = '0; mErr[k] = 1'b0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
               if (mBusy[k]) begin
                  if (mDone[k]) begin
                     if (rsp_ready) mBusy[k] = 1'b0;
                  end else if (cyc == mAcc[k] + latOf(k)) begin
                     modelAccess(k);
                     mDone[k] = 1'b1;
                     mZero[k] = 1'b0;
                  end
               end else if (req_valid) begin
                  mBusy[k] = 1'b1; mDone[k] = 1'b0; mAcc[k] = cyc;
                  mWe[k] = req_we; mAddr[k] = req_addr; mSize[k] = req_size;
                  mUns[k] = req_unsigned; mWdata[k] = req_wdata;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("req_ready", k, 32'(reqReady[k]), 32'(!mBusy[k]));
         chk("rsp_valid", k, 32'(rspValid[k]), 32'(mBusy[k] && mDone[k]));
         if ((mBusy[k] && mDone[k]) || mZero[k]) begin
            chk("rsp_rdata", k, rspRdata[k], mRdata[k]);
            chk("rsp_err", k, 32'(rspErr[k]), 32'(mErr[k]));
         end
      end
   end

   // ---------------- directed helpers ----------------
   logic [31:0] lastRd [NI];
   logic        lastErr [NI];
   logic [31:0] initWord [64];

   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
      int n;
      n = 0;
      while (reqReady != '1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) failNow("idle_wait");
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
      req_size = 2'($urandom_range(0, 3)); req_wdata = $urandom;
   endtask

   // Called just after the accept edge; records each instance's latency and response.
   task automatic finish();
      logic seen [NI];
      int   lat [NI];
      logic allSeen;
      for (int k = 0; k < NI; k++) begin seen[k] = 1'b0; lat[k] = 0; end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         allSeen = 1'b1;
         for (int k = 0; k < NI; k++) begin
            if (!seen[k] && rspValid[k]) begin
               seen[k] = 1'b1; lat[k] = c - 1;
               lastRd[k] = rspRdata[k]; lastErr[k] = rspErr[k];
            end
            allSeen = allSeen & seen[k];
         end
         if (allSeen && reqReady == '1) break;
      end
      for (int k = 0; k < NI; k++) begin
         if (!seen[k]) failNow("rsp_wait");
         else chk("latency", k, 32'(lat[k]), 32'(latOf(k)));
      end
   endtask

   task automatic doReq(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
      issue(we, addr, size, uns, wd);
      finish();
   endtask

   task automatic expectAll(input string nm, input logic [31:0] rd, input logic err);
      for (int k = 0; k < NI; k++) begin
         chk({nm, "_rdata"}, k, lastRd[k], rd);
         chk({nm, "_err"}, k, 32'(lastErr[k]), 32'(err));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [1:0] sz;
      logic [31:0] a;
      int sb;

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);

      for (int w = 0; w < 64; w++) begin
         initWord[w] = $urandom;
         doReq(1'b1, 32'(4*w), 2'd2, 1'b0, initWord[w]);
      end

      doReq(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
      expectAll("st_word", 32'h0, 1'b0);
      doReq(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      expectAll("ld_word", 32'hDEADBEEF, 1'b0);

      doReq(1'b1, 32'h10, 2'd2, 1'b0, 32'h0);
      doReq(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFF80);
      doReq(1'b1, 32'h12, 2'd1, 1'b0, 32'hABCD1234);
      doReq(1'b0, 32'h10, 2'd2, 1'b1, 32'h0);
      expectAll("subword_word", 32'h12348000, 1'b0);
      doReq(1'b0, 32'h11, 2'd0, 1'b0, 32'h0);
      expectAll("lb_signed", 32'hFFFFFF80, 1'b0);
      doReq(1'b0, 32'h11, 2'd0, 1'b1, 32'h0);
      expectAll("lb_unsigned", 32'h00000080, 1'b0);
      doReq(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
      expectAll("lh_signed", 32'h00001234, 1'b0);
      doReq(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
      expectAll("lb_signed_pos", 32'h00000012, 1'b0);

      doReq(1'b0, 32'h12, 2'd2, 1'b0, 32'h0);
      expectAll("misaligned_word", 32'h0, 1'b1);
      doReq(1'b0, 32'h13, 2'd1, 1'b0, 32'h0);
      expectAll("misaligned_half", 32'h0, 1'b1);
      doReq(1'b1, 32'h100, 2'd2, 1'b0, 32'hCAFEF00D);
      expectAll("out_of_range", 32'h0, 1'b1);
      doReq(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
      expectAll("oor_word0", initWord[0], 1'b0);
      doReq(1'b0, 32'hFC, 2'd2, 1'b0, 32'h0);
      expectAll("oor_word63", initWord[63], 1'b0);
      doReq(1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
      expectAll("size3", 32'h0, 1'b1);

      // Backpressure: responses held, further requests ignored.
      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      n = 0;
      while (rspValid != '1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) failNow("bp_valid_wait");
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h55555555;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            chk("bp_valid", k, 32'(rspValid[k]), 32'h1);
            chk("bp_rdata", k, rspRdata[k], 32'h12348000);
            chk("bp_ready", k, 32'(reqReady[k]), 32'h0);
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) chk("bp_release_ready", k, 32'(reqReady[k]), 32'h1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < NI; k++) chk("bp_reaccept", k, 32'(reqReady[k]), 32'h0);
      finish();
      expectAll("bp_reload", 32'h12348000, 1'b0);

      // Reset during WAIT drops the store for every latency.
      doReq(1'b1, 32'h20, 2'd2, 1'b0, 32'h11111111);
      issue(1'b1, 32'h20, 2'd2, 1'b0, 32'hAAAAAAAA);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      doReq(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
      expectAll("reset_drop", 32'h11111111, 1'b0);

      // Randomised traffic; instances may diverge and are tracked independently.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         sb = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
         a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(sb - 1);
         req_valid = ($urandom_range(0, 2) == 0);
         req_we = $urandom_range(0, 1);
         req_addr = a;
         req_size = sz;
         req_unsigned = $urandom_range(0, 1);
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (reqReady != '1 && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) failNow("drain_wait");
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
